cid_to_gcid_3d_pipe: RTL and testbench

- Pipelined, streaming converter from a home-relative 3D cell ID to an absolute global cell ID.
- Input: per-axis 2-bit neighbour code plus cell-fold ID. Output: global x/y/z, a flattened global index, and an invalid-code flag.
- Periodic wrap-around on each axis.
- Sits between the force/position record generators and the inter-FPGA routing logic; valid/ready handshake on both sides.

---
 rtl/MD_pkg.sv | 20 ++
 rtl/cid_wrap_axis.sv | 36 +++
 rtl/cid_to_gcid_3d_pipe.sv | 150 +++++++++++++++
 tb/tb_cid_to_gcid_3d_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/MD_pkg.sv
// Shared molecular-dynamics widths, neighbour-code encodings and the
// packed global cell ID record used by the cell-ID conversion pipeline.
package MD_pkg;

  localparam int CELL_ID_WIDTH        = 2;
  localparam int GLOBAL_CELL_ID_WIDTH = 2;
  localparam int CELL_FOLD_ID_WIDTH   = 2;
  localparam int NUM_CELL_FOLDS       = 2;

  localparam logic [CELL_ID_WIDTH-1:0] CID_MINUS = 2'b01;
  localparam logic [CELL_ID_WIDTH-1:0] CID_HOME  = 2'b10;
  localparam logic [CELL_ID_WIDTH-1:0] CID_PLUS  = 2'b11;

  typedef struct packed {
    logic [GLOBAL_CELL_ID_WIDTH-1:0] z;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] y;
    logic [GLOBAL_CELL_ID_WIDTH-1:0] x;
  } gcid_3d_t;

endpackage

// File: rtl/cid_wrap_axis.sv
// Single-axis neighbour resolver: turns a 2-bit neighbour code plus the home
// coordinate into an absolute coordinate with periodic wrap-around. Code 00
// is not a legal neighbour and yields coordinate 0 with err raised.
module cid_wrap_axis
  import MD_pkg::*;
#(
  parameter int GDIM  = 4,
  parameter int WIDTH = GLOBAL_CELL_ID_WIDTH
) (
  input  logic [CELL_ID_WIDTH-1:0] code,
  input  logic [WIDTH-1:0]         base,
  output logic [WIDTH-1:0]         coord,
  output logic                     err
);

  localparam logic [WIDTH-1:0] LAST     = WIDTH'(GDIM - 1);
  localparam logic [WIDTH:0]   GDIM_EXT = (WIDTH + 1)'(GDIM);

  logic [WIDTH:0] base_ext;
  logic [WIDTH:0] inc;

  // Resolve the code; the +/-1 is done one bit wider so the wrap compare sees the carry
  always_comb begin
    base_ext = {1'b0, base};
    inc      = base_ext + 1'b1;
    coord    = '0;
    err      = 1'b0;
    case (code)
      CID_MINUS: coord = (base_ext == '0) ? LAST : WIDTH'(base_ext - 1'b1);
      CID_HOME:  coord = base;
      CID_PLUS:  coord = (inc == GDIM_EXT) ? '0 : WIDTH'(inc);
      default:   err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/cid_to_gcid_3d_pipe.sv
// Two-stage streaming converter from home-relative 3D cell IDs to absolute
// global cell IDs with a flattened index. Stage 1 captures the codes and the
// fold-selected home base; stage 2 captures the wrapped coordinates.
// Optional build macro CID_TO_GCID_ERR_CNT_EN adds a saturating 16-bit count
// of erroneous records delivered downstream (o_err_cnt).
module cid_to_gcid_3d_pipe
  import MD_pkg::*;
#(
  parameter int NUM_FOLDS  = NUM_CELL_FOLDS,
  parameter int GDIM_X     = 4,
  parameter int GDIM_Y     = 4,
  parameter int GDIM_Z     = 4,
  parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_X [NUM_FOLDS] = '{default: '0},
  parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Y [NUM_FOLDS] = '{default: '0},
  parameter logic [GLOBAL_CELL_ID_WIDTH-1:0] GCELL_Z [NUM_FOLDS] = '{default: '0},
  parameter int FLAT_WIDTH = $clog2(GDIM_X * GDIM_Y * GDIM_Z)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [3*CELL_ID_WIDTH-1:0]      i_cid,
  input  logic [CELL_FOLD_ID_WIDTH-1:0]   i_fold_id,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [3*GLOBAL_CELL_ID_WIDTH-1:0] o_gcid,
  output logic [FLAT_WIDTH-1:0]           o_gcid_flat,
`ifdef CID_TO_GCID_ERR_CNT_EN
  output logic [15:0]                     o_err_cnt,
`endif
  output logic                            o_err
);

  localparam int CW = CELL_ID_WIDTH;

  gcid_3d_t                sel_base;
  logic                    fold_err;
  logic                    s1_valid;
  logic [3*CW-1:0]         s1_cid;
  gcid_3d_t                s1_base;
  logic                    s1_fold_err;
  gcid_3d_t                wrap;
  logic                    err_x, err_y, err_z;
  logic [FLAT_WIDTH-1:0]   wrap_flat;
  logic                    s2_valid;
  gcid_3d_t                s2_gcid;
  logic [FLAT_WIDTH-1:0]   s2_flat;
  logic                    s2_err;
  logic                    s1_advance;
  logic                    s2_advance;

  // Pick the home base for the requested fold; out-of-range folds fall back to origin
  always_comb begin
    sel_base = '0;
    fold_err = (int'(i_fold_id) >= NUM_FOLDS);
    for (int f = 0; f < NUM_FOLDS; f++) begin
      if (int'(i_fold_id) == f) begin
        sel_base.x = GCELL_X[f];
        sel_base.y = GCELL_Y[f];
        sel_base.z = GCELL_Z[f];
      end
    end
  end

  // Stage handshake: each stage moves when it is empty or its successor moves
  always_comb begin
    s2_advance = ~s2_valid | i_ready;
    s1_advance = ~s1_valid | s2_advance;
    o_ready    = s1_advance;
  end

  // Stage 1 register: raw codes, selected base and fold-range error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_cid      <= '0;
      s1_base     <= '0;
      s1_fold_err <= 1'b0;
    end else if (s1_advance) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_cid      <= i_cid;
        s1_base     <= sel_base;
        s1_fold_err <= fold_err;
      end
    end
  end

  cid_wrap_axis #(.GDIM(GDIM_X), .WIDTH(GLOBAL_CELL_ID_WIDTH)) u_wrap_x (
    .code (s1_cid[CW-1:0]),
    .base (s1_base.x),
    .coord(wrap.x),
    .err  (err_x)
  );

  cid_wrap_axis #(.GDIM(GDIM_Y), .WIDTH(GLOBAL_CELL_ID_WIDTH)) u_wrap_y (
    .code (s1_cid[2*CW-1:CW]),
    .base (s1_base.y),
    .coord(wrap.y),
    .err  (err_y)
  );

  cid_wrap_axis #(.GDIM(GDIM_Z), .WIDTH(GLOBAL_CELL_ID_WIDTH)) u_wrap_z (
    .code (s1_cid[3*CW-1:2*CW]),
    .base (s1_base.z),
    .coord(wrap.z),
    .err  (err_z)
  );

  // Flattened index x + GDIM_X*(y + GDIM_Y*z) using constant multipliers only
  always_comb begin
    wrap_flat = FLAT_WIDTH'(wrap.x)
              + FLAT_WIDTH'(GDIM_X) * (FLAT_WIDTH'(wrap.y)
              + FLAT_WIDTH'(GDIM_Y) * FLAT_WIDTH'(wrap.z));
  end

  // Stage 2 register: wrapped coordinates, flat index and combined error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_gcid  <= '0;
      s2_flat  <= '0;
      s2_err   <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_gcid <= wrap;
        s2_flat <= wrap_flat;
        s2_err  <= s1_fold_err | err_x | err_y | err_z;
      end
    end
  end

  assign o_valid     = s2_valid;
  assign o_gcid      = s2_gcid;
  assign o_gcid_flat = s2_flat;
  assign o_err       = s2_err;

`ifdef CID_TO_GCID_ERR_CNT_EN
  // Count erroneous records as they are handed downstream, holding at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_err_cnt <= '0;
    end else if (s2_valid && i_ready && s2_err && (o_err_cnt != 16'hFFFF)) begin
      o_err_cnt <= o_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cid_to_gcid_3d_pipe.sv
// Bench for cid_to_gcid_3d_pipe: directed vector table, backpressure and
// mid-stream reset sequences, then randomized streaming against a
// modular-arithmetic reference model and an in-order scoreboard.
module tb_cid_to_gcid_3d_pipe;

  typedef struct {
    logic [1:0] gx;
    logic [1:0] gy;
    logic [1:0] gz;
    logic [5:0] flat;
    logic       err;
  } res_t;

  typedef struct {
    logic [1:0] fold;
    logic [1:0] cx;
    logic [1:0] cy;
    logic [1:0] cz;
    logic [1:0] gx;
    logic [1:0] gy;
    logic [1:0] gz;
    logic [5:0] flat;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_valid;
  logic       o_ready;
  logic [5:0] i_cid;
  logic [1:0] i_fold_id;
  logic       o_valid;
  logic       i_ready;
  logic [5:0] o_gcid;
  logic [5:0] o_gcid_flat;
  logic       o_err;
`ifdef CID_TO_GCID_ERR_CNT_EN
  logic [15:0] o_err_cnt;
  int          exp_err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int out_count = 0;
  res_t exp_q[$];
  int base_x[2] = '{0, 3};
  int base_y[2] = '{0, 2};
  int base_z[2] = '{0, 1};

  logic       hold = 1'b0;
  logic [5:0] prev_gcid;
  logic [5:0] prev_flat;
  logic       prev_err;

  always #5 clk = ~clk;

  cid_to_gcid_3d_pipe #(
    .NUM_FOLDS(2),
    .GDIM_X(4),
    .GDIM_Y(4),
    .GDIM_Z(4),
    .GCELL_X('{2'd0, 2'd3}),
    .GCELL_Y('{2'd0, 2'd2}),
    .GCELL_Z('{2'd0, 2'd1})
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_cid(i_cid),
    .i_fold_id(i_fold_id),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_gcid(o_gcid),
    .o_gcid_flat(o_gcid_flat),
`ifdef CID_TO_GCID_ERR_CNT_EN
    .o_err_cnt(o_err_cnt),
`endif
    .o_err(o_err)
  );

  // Reference: each code is an offset of -1/0/+1 from the home cell, taken modulo 4
  function automatic res_t model(input logic [1:0] fold, input logic [5:0] cid);
    res_t r;
    int   coord[3];
    int   base;
    int   code;
    r.err = (fold >= 2);
    for (int a = 0; a < 3; a++) begin
      if (fold >= 2) base = 0;
      else if (a == 0) base = base_x[fold];
      else if (a == 1) base = base_y[fold];
      else base = base_z[fold];
      code = int'(cid >> (2 * a)) & 3;
      if (code == 0) begin
        coord[a] = 0;
        r.err = 1'b1;
      end else begin
        coord[a] = (base + (code - 2) + 4) % 4;
      end
    end
    r.gx   = 2'(coord[0]);
    r.gy   = 2'(coord[1]);
    r.gz   = 2'(coord[2]);
    r.flat = 6'(coord[0] + 4 * (coord[1] + 4 * coord[2]));
    return r;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [1:0] fold, input logic [5:0] cid);
    i_valid   = vld;
    i_fold_id = fold;
    i_cid     = cid;
  endtask

  // Scoreboard mid-cycle: hold stability, in-order outputs, and queue accepted inputs
  always @(negedge clk) begin
    res_t e;
    if (rst) begin
      exp_q.delete();
      hold = 1'b0;
`ifdef CID_TO_GCID_ERR_CNT_EN
      exp_err_cnt = 0;
`endif
    end else begin
`ifdef CID_TO_GCID_ERR_CNT_EN
      checkOutput("err_cnt", int'(o_err_cnt), exp_err_cnt);
`endif
      if (hold) begin
        checkOutput("stall_valid", int'(o_valid), 1);
        checkOutput("stall_data", int'({o_gcid, o_gcid_flat, o_err}),
                    int'({prev_gcid, prev_flat, prev_err}));
      end
      if (o_valid && i_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_gcid", int'(o_gcid), int'({e.gz, e.gy, e.gx}));
          checkOutput("sb_flat", int'(o_gcid_flat), int'(e.flat));
          checkOutput("sb_err", int'(o_err), int'(e.err));
        end
`ifdef CID_TO_GCID_ERR_CNT_EN
        if (o_err && exp_err_cnt < 65535) exp_err_cnt++;
`endif
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_fold_id, i_cid));
      hold      = o_valid && !i_ready;
      prev_gcid = o_gcid;
      prev_flat = o_gcid_flat;
      prev_err  = o_err;
    end
  end

  initial begin
    vec_t vecs[7];
    logic [1:0] rec_fold[8];
    logic [5:0] rec_cid[8];
    int idx;
    int start_out;
    logic got_low;
    logic fire;

    vecs[0] = '{fold: 2'd0, cx: 2'b01, cy: 2'b10, cz: 2'b11, gx: 2'd3, gy: 2'd0, gz: 2'd1, flat: 6'd19, err: 1'b0};
    vecs[1] = '{fold: 2'd1, cx: 2'b11, cy: 2'b11, cz: 2'b01, gx: 2'd0, gy: 2'd3, gz: 2'd0, flat: 6'd12, err: 1'b0};
    vecs[2] = '{fold: 2'd1, cx: 2'b00, cy: 2'b10, cz: 2'b10, gx: 2'd0, gy: 2'd2, gz: 2'd1, flat: 6'd24, err: 1'b1};
    vecs[3] = '{fold: 2'd2, cx: 2'b10, cy: 2'b10, cz: 2'b10, gx: 2'd0, gy: 2'd0, gz: 2'd0, flat: 6'd0,  err: 1'b1};
    vecs[4] = '{fold: 2'd1, cx: 2'b10, cy: 2'b10, cz: 2'b10, gx: 2'd3, gy: 2'd2, gz: 2'd1, flat: 6'd27, err: 1'b0};
    vecs[5] = '{fold: 2'd0, cx: 2'b01, cy: 2'b01, cz: 2'b01, gx: 2'd3, gy: 2'd3, gz: 2'd3, flat: 6'd63, err: 1'b0};
    vecs[6] = '{fold: 2'd3, cx: 2'b01, cy: 2'b11, cz: 2'b11, gx: 2'd3, gy: 2'd1, gz: 2'd1, flat: 6'd23, err: 1'b1};

    rst = 1'b1;
    i_ready = 1'b1;
    applyStimulus(1'b0, 2'd0, 6'd0);
    #2;
    checkOutput("reset_valid", int'(o_valid), 0);
    checkOutput("reset_err", int'(o_err), 0);
    checkOutput("reset_gcid", int'(o_gcid), 0);
    checkOutput("reset_flat", int'(o_gcid_flat), 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", int'(o_ready), 1);

    // Directed table: exact two-cycle latency and expected record contents
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, vecs[i].fold, {vecs[i].cz, vecs[i].cy, vecs[i].cx});
      checkOutput("vec_ready", int'(o_ready), 1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 2'd0, 6'd0);
      checkOutput("vec_latency_early", int'(o_valid), 0);
      @(posedge clk); #1;
      checkOutput("vec_valid", int'(o_valid), 1);
      checkOutput("vec_gx", int'(o_gcid[1:0]), int'(vecs[i].gx));
      checkOutput("vec_gy", int'(o_gcid[3:2]), int'(vecs[i].gy));
      checkOutput("vec_gz", int'(o_gcid[5:4]), int'(vecs[i].gz));
      checkOutput("vec_flat", int'(o_gcid_flat), int'(vecs[i].flat));
      checkOutput("vec_err", int'(o_err), int'(vecs[i].err));
      @(posedge clk); #1;
    end
`ifdef CID_TO_GCID_ERR_CNT_EN
    checkOutput("err_cnt_after_table", int'(o_err_cnt), 3);
`endif

    // Backpressure: 8 back-to-back records, downstream stalled in cycles 3..6
    for (int k = 0; k < 8; k++) begin
      rec_fold[k] = 2'($urandom_range(0, 3));
      rec_cid[k]  = 6'($urandom);
    end
    idx = 0;
    got_low = 1'b0;
    start_out = out_count;
    for (int cyc = 0; cyc < 30; cyc++) begin
      i_ready = !(cyc >= 3 && cyc <= 6);
      if (idx < 8) applyStimulus(1'b1, rec_fold[idx], rec_cid[idx]);
      else applyStimulus(1'b0, 2'd0, 6'd0);
      #1;
      if (!o_ready) got_low = 1'b1;
      fire = i_valid && o_ready;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    checkOutput("bp_all_accepted", idx, 8);
    checkOutput("bp_ready_dropped", int'(got_low), 1);
    checkOutput("bp_all_emerged", out_count - start_out, 8);
    checkOutput("bp_queue_empty", exp_q.size(), 0);

    // Mid-stream reset with two records in flight, asserted off the clock edge
    i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 1)), 6'b101010);
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 2'd0, 6'd0);
    checkOutput("pre_reset_valid", int'(o_valid), 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_valid", int'(o_valid), 0);
    checkOutput("async_reset_flat", int'(o_gcid_flat), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checkOutput("release_ready", int'(o_ready), 1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      checkOutput("no_stale_record", int'(o_valid), 0);
    end

    // Randomized streaming with random valid and ready
    for (int cyc = 0; cyc < 400; cyc++) begin
      i_ready = ($urandom_range(0, 9) < 7);
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 6'($urandom));
      @(posedge clk); #1;
    end
    applyStimulus(1'b0, 2'd0, 6'd0);
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && exp_q.size() != 0; cyc++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
